turn_sequencer: RTL and testbench

TURN_SEQUENCER -- requirements
Module: turn_sequencer

---
 rtl/tank_pkg.sv | 44 ++++
 rtl/player_track.sv | 68 ++++++
 rtl/turn_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_turn_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tank_pkg
// Description : Shared storage mode codes, direction codes and the frame
//               sequencer state encoding for the tank game datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package tank_pkg;

    // Storage mode select codes
    localparam logic [3:0] c_MODE_NOP       = 4'b0000;
    localparam logic [3:0] c_MODE_TANK1     = 4'b0001;
    localparam logic [3:0] c_MODE_TANK1_RD  = 4'b0010;
    localparam logic [3:0] c_MODE_PROJ1     = 4'b0011;
    localparam logic [3:0] c_MODE_PROJ1_RD  = 4'b0100;
    localparam logic [3:0] c_MODE_TANK2     = 4'b0101;
    localparam logic [3:0] c_MODE_TANK2_RD  = 4'b0110;
    localparam logic [3:0] c_MODE_PROJ2     = 4'b0111;
    localparam logic [3:0] c_MODE_CLEAR     = 4'b1000;

    // Direction codes; any other value is not a legal move request
    localparam logic [7:0] c_DIR_UP    = 8'h00;
    localparam logic [7:0] c_DIR_DOWN  = 8'h01;
    localparam logic [7:0] c_DIR_LEFT  = 8'h03;
    localparam logic [7:0] c_DIR_RIGHT = 8'h07;

    // Frame sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEL     = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_LOAD    = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } seq_state_t;

    function automatic logic is_legal_dir(input logic [7:0] dir);
        return (dir == c_DIR_UP) || (dir == c_DIR_DOWN) ||
               (dir == c_DIR_LEFT) || (dir == c_DIR_RIGHT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_track.sv
`default_nettype none
// ============================================================================
// Module      : player_track
// Description : Local copy of one player's tank position/direction and its
//               single projectile (active flag, position, direction).
// Revision    : 1.0 - initial release
// ============================================================================
module player_track
    import tank_pkg::*;
#(
    parameter logic [7:0] RESET_POS = 8'h00,
    parameter logic [7:0] RESET_DIR = c_DIR_DOWN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_fire,
    input  logic       i_tank_cap,
    input  logic [7:0] i_tank_dir,
    input  logic       i_proj_cap,
    input  logic       i_proj_kill,
    input  logic [7:0] i_pos_q,
    output logic [7:0] o_pos,
    output logic       o_proj_active,
    output logic [7:0] o_proj_pos,
    output logic [7:0] o_proj_dir
);

    logic [7:0] r_pos;
    logic [7:0] r_dir;
    logic       r_proj_active;
    logic [7:0] r_proj_pos;
    logic [7:0] r_proj_dir;

    // Fire launches from the tank's pre-move state; captures overwrite positions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos         <= RESET_POS;
            r_dir         <= RESET_DIR;
            r_proj_active <= 1'b0;
            r_proj_pos    <= 8'h00;
            r_proj_dir    <= 8'h00;
        end else begin
            if (i_fire && !r_proj_active) begin
                r_proj_active <= 1'b1;
                r_proj_dir    <= r_dir;
                r_proj_pos    <= r_pos;
            end
            // Direction follows the request even when the tank is pinned at an edge
            if (i_tank_cap) begin
                r_pos <= i_pos_q;
                r_dir <= i_tank_dir;
            end
            if (i_proj_cap) begin
                r_proj_pos <= i_pos_q;
                if (i_proj_kill) begin
                    r_proj_active <= 1'b0;
                end
            end
        end
    end

    assign o_pos         = r_pos;
    assign o_proj_active = r_proj_active;
    assign o_proj_pos    = r_proj_pos;
    assign o_proj_dir    = r_proj_dir;

endmodule
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : turn_sequencer
// Description : Per-frame sequencer that walks the four game objects (tank1,
//               projectile1, tank2, projectile2) through the position storage
//               and resolves projectile hits and edge exits.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_sequencer
    import tank_pkg::*;
#(
    parameter int STORE_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       p1_move,
    input  logic       p2_move,
    input  logic [7:0] p1_dir,
    input  logic [7:0] p2_dir,
    input  logic       p1_fire,
    input  logic       p2_fire,
    input  logic [7:0] q,
    output logic [3:0] mode,
    output logic       wren,
    output logic       load_out,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       busy,
    output logic       frame_done,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic       overrun
);

    localparam int c_WCNT_W = (STORE_LAT > 1) ? $clog2(STORE_LAT) : 1;
    localparam logic [c_WCNT_W-1:0] c_WAIT_LAST =
        c_WCNT_W'((STORE_LAT > 0) ? STORE_LAT - 1 : 0);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [1:0]           r_slot;
    logic [c_WCNT_W-1:0]  r_wait_cnt;
    logic                 r_mv1, r_mv2;
    logic [7:0]           r_dir1, r_dir2;
    logic                 r_hit1, r_hit2;
    logic [3:0]           r_mode;
    logic [7:0]           r_data;
    logic                 r_overrun;

    logic                 w_frame_start;
    logic                 w_slot_active;
    logic [3:0]           w_slot_mode;
    logic [7:0]           w_slot_data;
    logic                 w_slot_leave;
    logic                 w_cap;
    logic                 w_p1_hit, w_p2_hit;
    logic [7:0]           w_t1_pos, w_t2_pos;
    logic                 w_pj1_active, w_pj2_active;
    logic [7:0]           w_pj1_pos, w_pj2_pos;
    logic [7:0]           w_pj1_dir, w_pj2_dir;

    assign w_frame_start = (r_state == S_IDLE) && tick;
    assign w_cap         = (r_state == S_CAPTURE);
    assign w_slot_leave  = ((r_state == S_SEL) && !w_slot_active) || w_cap;
    assign w_p1_hit      = (q == w_t2_pos);
    assign w_p2_hit      = (q == w_t1_pos);

    player_track #(
        .RESET_POS (8'h00),
        .RESET_DIR (c_DIR_DOWN)
    ) u_player1 (
        .clk           (clk),
        .reset         (reset),
        .i_fire        (w_frame_start && p1_fire),
        .i_tank_cap    (w_cap && (r_slot == 2'd0)),
        .i_tank_dir    (r_dir1),
        .i_proj_cap    (w_cap && (r_slot == 2'd1)),
        .i_proj_kill   (w_p1_hit || (q == w_pj1_pos)),
        .i_pos_q       (q),
        .o_pos         (w_t1_pos),
        .o_proj_active (w_pj1_active),
        .o_proj_pos    (w_pj1_pos),
        .o_proj_dir    (w_pj1_dir)
    );

    player_track #(
        .RESET_POS (8'hFF),
        .RESET_DIR (c_DIR_UP)
    ) u_player2 (
        .clk           (clk),
        .reset         (reset),
        .i_fire        (w_frame_start && p2_fire),
        .i_tank_cap    (w_cap && (r_slot == 2'd2)),
        .i_tank_dir    (r_dir2),
        .i_proj_cap    (w_cap && (r_slot == 2'd3)),
        .i_proj_kill   (w_p2_hit || (q == w_pj2_pos)),
        .i_pos_q       (q),
        .o_pos         (w_t2_pos),
        .o_proj_active (w_pj2_active),
        .o_proj_pos    (w_pj2_pos),
        .o_proj_dir    (w_pj2_dir)
    );

    // Decode whether the current slot needs a storage transaction, and its mode/data
    always_comb begin
        w_slot_active = 1'b0;
        w_slot_mode   = c_MODE_NOP;
        w_slot_data   = 8'h00;
        case (r_slot)
            2'd0: begin
                w_slot_active = r_mv1 && is_legal_dir(r_dir1);
                w_slot_mode   = c_MODE_TANK1;
                w_slot_data   = r_dir1;
            end
            2'd1: begin
                w_slot_active = w_pj1_active;
                w_slot_mode   = c_MODE_PROJ1;
                w_slot_data   = w_pj1_dir;
            end
            2'd2: begin
                w_slot_active = r_mv2 && is_legal_dir(r_dir2);
                w_slot_mode   = c_MODE_TANK2;
                w_slot_data   = r_dir2;
            end
            default: begin
                w_slot_active = w_pj2_active;
                w_slot_mode   = c_MODE_PROJ2;
                w_slot_data   = w_pj2_dir;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_nxt = r_state;
        wren        = 1'b0;
        load_out    = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;
        hit_p1      = 1'b0;
        hit_p2      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (tick) begin
                    w_state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                if (w_slot_active) begin
                    w_state_nxt = S_ISSUE;
                end else if (r_slot == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_ISSUE: begin
                wren        = 1'b1;
                w_state_nxt = (STORE_LAT == 0) ? S_LOAD : S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load_out    = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = (r_slot == 2'd3) ? S_DONE : S_SEL;
            end
            S_DONE: begin
                frame_done  = 1'b1;
                hit_p1      = r_hit1;
                hit_p2      = r_hit2;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame bookkeeping: request latch, slot walk, wait timer, held mode/data, hit and overrun flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot     <= 2'd0;
            r_wait_cnt <= '0;
            r_mv1      <= 1'b0;
            r_mv2      <= 1'b0;
            r_dir1     <= 8'h00;
            r_dir2     <= 8'h00;
            r_hit1     <= 1'b0;
            r_hit2     <= 1'b0;
            r_mode     <= 4'h0;
            r_data     <= 8'h00;
            r_overrun  <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_mv1  <= p1_move;
                r_dir1 <= p1_dir;
                r_mv2  <= p2_move;
                r_dir2 <= p2_dir;
                r_slot <= 2'd0;
                r_hit1 <= 1'b0;
                r_hit2 <= 1'b0;
            end else if (w_slot_leave) begin
                r_slot <= r_slot + 2'd1;
            end
            if (tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if ((r_state == S_SEL) && w_slot_active) begin
                r_mode <= w_slot_mode;
                r_data <= w_slot_data;
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            // A hit takes priority; the edge case never raises a hit flag
            if (w_cap && (r_slot == 2'd1) && w_p1_hit) begin
                r_hit1 <= 1'b1;
            end
            if (w_cap && (r_slot == 2'd3) && w_p2_hit) begin
                r_hit2 <= 1'b1;
            end
        end
    end

    assign mode    = r_mode;
    assign data    = r_data;
    assign address = 8'h00;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_sequencer
// Description : Directed scoreboard bench for turn_sequencer. Each frame
//               queues its expected storage strobes and frame end; a monitor
//               pops and compares whenever the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_sequencer;

    localparam int K_ISSUE = 0;
    localparam int K_LOAD  = 1;
    localparam int K_DONE  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       p1_move, p2_move, p1_fire, p2_fire;
    logic [7:0] p1_dir, p2_dir;
    logic [7:0] q = 8'h00;
    logic [3:0] mode;
    logic       wren, load_out, busy, frame_done, hit_p1, hit_p2, overrun;
    logic [7:0] address, data;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] mode;
        logic [7:0] data;
        logic       h1;
        logic       h2;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] q_plan[$];
    int         cyc    = 0;
    int         t0     = 0;
    int         errors = 0;
    int         checks = 0;

    turn_sequencer #(.STORE_LAT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .p1_move    (p1_move),
        .p2_move    (p2_move),
        .p1_dir     (p1_dir),
        .p2_dir     (p2_dir),
        .p1_fire    (p1_fire),
        .p2_fire    (p2_fire),
        .q          (q),
        .mode       (mode),
        .wren       (wren),
        .load_out   (load_out),
        .address    (address),
        .data       (data),
        .busy       (busy),
        .frame_done (frame_done),
        .hit_p1     (hit_p1),
        .hit_p2     (hit_p2),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Storage model: present the planned position right after each load strobe
    always @(negedge clk) begin
        if (load_out) begin
            if (q_plan.size() > 0) q <= q_plan.pop_front();
            else                   q <= 8'hEE;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        if (!reset) begin
            if (wren || load_out || frame_done) begin
                k = wren ? K_ISSUE : (load_out ? K_LOAD : K_DONE);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", k, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check({e.tag, "_kind"},  k,   e.kind);
                    check({e.tag, "_cycle"}, cyc, e.cyc);
                    if (k == K_ISSUE) begin
                        check({e.tag, "_mode"}, mode, e.mode);
                        check({e.tag, "_data"}, data, e.data);
                    end else if (k == K_LOAD) begin
                        check({e.tag, "_mode"}, mode, e.mode);
                    end else begin
                        check({e.tag, "_hits"}, {hit_p1, hit_p2}, {e.h1, e.h2});
                    end
                end
            end
            if ((hit_p1 || hit_p2) && !frame_done)
                check("hit_outside_done", {hit_p1, hit_p2}, 2'b00);
            if (address != 8'h00)
                check("address", address, 8'h00);
        end
    end

    task automatic push_ev(input int kind, input int off, input logic [3:0] m, input logic [7:0] d,
                           input logic h1, input logic h2, input string tag);
        exp_t e;
        e.kind = kind; e.cyc = t0 + off; e.mode = m; e.data = d;
        e.h1 = h1; e.h2 = h2; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic ev_issue(input int off, input logic [3:0] m, input logic [7:0] d, input string tag);
        push_ev(K_ISSUE, off, m, d, 1'b0, 1'b0, {tag, "_issue"});
    endtask

    task automatic ev_load(input int off, input logic [3:0] m, input string tag);
        push_ev(K_LOAD, off, m, 8'h00, 1'b0, 1'b0, {tag, "_load"});
    endtask

    task automatic ev_done(input int off, input logic h1, input logic h2, input string tag);
        push_ev(K_DONE, off, 4'h0, 8'h00, h1, h2, {tag, "_done"});
    endtask

    task automatic start_frame(input logic m1, input logic [7:0] d1, input logic f1,
                               input logic m2, input logic [7:0] d2, input logic f2);
        @(negedge clk);
        t0 = cyc;
        p1_move = m1; p1_dir = d1; p1_fire = f1;
        p2_move = m2; p2_dir = d2; p2_fire = f2;
        tick = 1'b1;
    endtask

    task automatic clear_inputs();
        tick = 1'b0;
        p1_move = 1'b0; p1_dir = 8'h00; p1_fire = 1'b0;
        p2_move = 1'b0; p2_dir = 8'h00; p2_fire = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic end_frame(input string tag);
        @(negedge clk);
        clear_inputs();
        wait_idle(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {mode, wren, load_out, address, data, busy, frame_done, hit_p1, hit_p2, overrun}, 27'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero(tag);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_state");
        reset = 1'b0;

        // Tank1 moves RIGHT from 00 to 01
        start_frame(1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
        q_plan.push_back(8'h01);
        ev_issue(2, 4'b0001, 8'h07, "t1_right");
        ev_load(5, 4'b0001, "t1_right");
        ev_done(10, 1'b0, 1'b0, "t1_right");
        end_frame("t1_right");

        // Empty frame
        start_frame(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        ev_done(5, 1'b0, 1'b0, "empty");
        end_frame("empty");

        do_reset("reset_between");

        // Tank1 at 00 facing DOWN fires; projectile flies to 40
        start_frame(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        q_plan.push_back(8'h40);
        ev_issue(3, 4'b0011, 8'h01, "fire1");
        ev_load(6, 4'b0011, "fire1");
        ev_done(10, 1'b0, 1'b0, "fire1");
        end_frame("fire1");

        // Tank1 turns RIGHT while refiring: projectile keeps direction DOWN
        start_frame(1'b1, 8'h07, 1'b1, 1'b0, 8'h00, 1'b0);
        q_plan.push_back(8'h01);
        q_plan.push_back(8'h41);
        ev_issue(2, 4'b0001, 8'h07, "refire_t1");
        ev_load(5, 4'b0001, "refire_t1");
        ev_issue(8, 4'b0011, 8'h01, "refire_p1");
        ev_load(11, 4'b0011, "refire_p1");
        ev_done(15, 1'b0, 1'b0, "refire");
        end_frame("refire");

        // Refire still ignored; projectile stays at 41 -> edge, no hit
        start_frame(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        q_plan.push_back(8'h41);
        ev_issue(3, 4'b0011, 8'h01, "edge1");
        ev_load(6, 4'b0011, "edge1");
        ev_done(10, 1'b0, 1'b0, "edge1");
        end_frame("edge1");

        // Tank2 moves UP from FF to 20; projectile1 no longer active
        start_frame(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        q_plan.push_back(8'h20);
        ev_issue(4, 4'b0101, 8'h00, "t2_up");
        ev_load(7, 4'b0101, "t2_up");
        ev_done(10, 1'b0, 1'b0, "t2_up");
        end_frame("t2_up");

        // Tank1 (01, RIGHT) fires; projectile lands on tank2 at 20
        start_frame(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        q_plan.push_back(8'h20);
        ev_issue(3, 4'b0011, 8'h07, "hit1");
        ev_load(6, 4'b0011, "hit1");
        ev_done(10, 1'b1, 1'b0, "hit1");
        end_frame("hit1");

        // Illegal direction 02: tank slot inactive; projectile gone after hit
        start_frame(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
        ev_done(5, 1'b0, 1'b0, "bad_dir");
        end_frame("bad_dir");

        // Tank2 (20, UP) fires; projectile lands on tank1 at 01
        start_frame(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        q_plan.push_back(8'h01);
        ev_issue(5, 4'b0111, 8'h00, "hit2");
        ev_load(8, 4'b0111, "hit2");
        ev_done(10, 1'b0, 1'b1, "hit2");
        end_frame("hit2");

        // Tank2 pinned: turns LEFT but storage returns the same position
        start_frame(1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0);
        q_plan.push_back(8'h20);
        ev_issue(4, 4'b0101, 8'h03, "t2_pinned");
        ev_load(7, 4'b0101, "t2_pinned");
        ev_done(10, 1'b0, 1'b0, "t2_pinned");
        end_frame("t2_pinned");

        // Tank2 fires with its new LEFT direction; projectile moves to 55
        start_frame(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        q_plan.push_back(8'h55);
        ev_issue(5, 4'b0111, 8'h03, "fire2");
        ev_load(8, 4'b0111, "fire2");
        ev_done(10, 1'b0, 1'b0, "fire2");
        end_frame("fire2");

        // Tick while busy: overrun set, frame carries on (projectile2 still active)
        check("overrun_before", overrun, 1'b0);
        start_frame(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        q_plan.push_back(8'h56);
        ev_issue(5, 4'b0111, 8'h03, "ovr");
        ev_load(8, 4'b0111, "ovr");
        ev_done(10, 1'b0, 1'b0, "ovr");
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("overrun_busy_tick", overrun, 1'b1);
        check("overrun_busy_kept", busy, 1'b1);
        wait_idle("ovr");

        do_reset("reset_clears_overrun");

        // Tick landing in the DONE cycle counts as overrun and starts nothing
        start_frame(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        ev_done(5, 1'b0, 1'b0, "done_tick");
        @(negedge clk);
        clear_inputs();
        repeat (4) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("overrun_done_tick", overrun, 1'b1);
        check("done_tick_idle", busy, 1'b0);
        @(negedge clk);
        check("done_tick_still_idle", busy, 1'b0);

        do_reset("reset_after_done_tick");

        // Reset during WAIT abandons the frame
        start_frame(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        ev_issue(2, 4'b0001, 8'h01, "abort");
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_in_wait");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle", busy, 1'b0);

        check("pending_expectations", exp_q.size(), 0);
        check("pending_positions", q_plan.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a frame never ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
